// File: rtl/pipelined_barrel_shifter_if.sv
// Operation/result handshake bundle for pipelined_barrel_shifter.
// The flag outputs exist only when SHIFTER_FLAGS_EN is defined.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH     = 64,
    parameter int TAG_WIDTH = 4
);
    localparam int AMT_W = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [AMT_W-1:0]     in_amount;
    logic [2:0]           in_op;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic [TAG_WIDTH-1:0] out_tag;

`ifdef SHIFTER_FLAGS_EN
    logic                 out_carry;
    logic                 out_zero;

    modport master (
        output in_valid, in_data, in_amount, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_carry, out_zero
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_carry, out_zero
    );
`else
    modport master (
        output in_valid, in_data, in_amount, in_op, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
    modport slave (
        input  in_valid, in_data, in_amount, in_op, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready flow control and tag pass-through.
// Define SHIFTER_FLAGS_EN to add the out_carry/out_zero result flags.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 64,
    parameter int PIPE_REGS = 2,
    parameter int TAG_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int AMT_W = $clog2(WIDTH);
    localparam int GRP   = (AMT_W + PIPE_REGS - 1) / PIPE_REGS;

    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    generate
        if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
            $fatal(1, "pipelined_barrel_shifter: WIDTH must be a power of two >= 8");
        end
        if (PIPE_REGS < 1 || PIPE_REGS > AMT_W) begin : g_bad_pipe
            $fatal(1, "pipelined_barrel_shifter: PIPE_REGS must be in 1..log2(WIDTH)");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = v[WIDTH-1-b];
        end
        return r;
    endfunction

    function automatic logic is_right(input logic [2:0] op);
        return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
    endfunction

    // One mux level: left shift by sh, low bits filled by wrap-around or the fill bit.
    function automatic logic [WIDTH-1:0] shl_level(input logic [WIDTH-1:0] v, input int sh,
                                                   input logic rot, input logic fill);
        logic [WIDTH-1:0] wrap;
        if (rot) begin
            wrap = v >> (WIDTH - sh);
        end else begin
            wrap = fill ? ~({WIDTH{1'b1}} << sh) : '0;
        end
        return (v << sh) | wrap;
    endfunction

    logic [PIPE_REGS-1:0] vld_q,  vld_d;
    logic [PIPE_REGS-1:0] sign_q, sign_d;
    logic [WIDTH-1:0]     data_q [PIPE_REGS];
    logic [WIDTH-1:0]     data_d [PIPE_REGS];
    logic [AMT_W-1:0]     amt_q  [PIPE_REGS];
    logic [AMT_W-1:0]     amt_d  [PIPE_REGS];
    logic [2:0]           op_q   [PIPE_REGS];
    logic [2:0]           op_d   [PIPE_REGS];
    logic [TAG_WIDTH-1:0] tag_q  [PIPE_REGS];
    logic [TAG_WIDTH-1:0] tag_d  [PIPE_REGS];
    logic                 stage0_ld;
`ifdef SHIFTER_FLAGS_EN
    logic [PIPE_REGS-1:0] carry_q, carry_d;
    logic                 zero_q,  zero_d;
`endif

    always_comb begin
        logic [PIPE_REGS-1:0] ld;
        logic                 chain;
        logic [WIDTH-1:0]     cur;
        logic [WIDTH-1:0]     tmp;
        logic [AMT_W-1:0]     amt;
        logic [2:0]           op;
        logic                 sgn;
        logic                 vin;
        logic                 cry;
        logic [TAG_WIDTH-1:0] tg;

        ld    = '0;
        chain = bus.out_ready;
        cur   = '0;
        tmp   = '0;
        amt   = '0;
        op    = '0;
        sgn   = 1'b0;
        vin   = 1'b0;
        cry   = 1'b0;
        tg    = '0;
`ifdef SHIFTER_FLAGS_EN
        carry_d = carry_q;
        zero_d  = zero_q;
`endif

        // A stage loads when it is empty or everything downstream of it moves.
        for (int k = PIPE_REGS - 1; k >= 0; k--) begin
            chain = chain | ~vld_q[k];
            ld[k] = chain;
        end
        stage0_ld = ld[0];

        for (int k = 0; k < PIPE_REGS; k++) begin
            if (k == 0) begin
                vin = bus.in_valid;
                op  = bus.in_op;
                sgn = bus.in_data[WIDTH-1];
                tg  = bus.in_tag;
                amt = (bus.in_op > OP_ROR) ? '0 : bus.in_amount;
                cur = is_right(bus.in_op) ? bit_rev(bus.in_data) : bus.in_data;
                cry = 1'b0;
            end else begin
                vin = vld_q[k-1];
                op  = op_q[k-1];
                sgn = sign_q[k-1];
                tg  = tag_q[k-1];
                amt = amt_q[k-1];
                cur = data_q[k-1];
`ifdef SHIFTER_FLAGS_EN
                cry = carry_q[k-1];
`endif
            end

            // Right-direction ops run reversed, so every level is a left shift.
            for (int l = 0; l < AMT_W; l++) begin
                if ((l / GRP) == k && amt[l]) begin
                    tmp = cur >> (WIDTH - (1 << l));
                    cry = tmp[0];
                    cur = shl_level(cur, 1 << l, (op == OP_ROL) || (op == OP_ROR),
                                    (op == OP_SRA) && sgn);
                end
            end
            if (k == PIPE_REGS - 1 && is_right(op)) begin
                cur = bit_rev(cur);
            end

            vld_d[k]  = vld_q[k];
            data_d[k] = data_q[k];
            amt_d[k]  = amt_q[k];
            op_d[k]   = op_q[k];
            sign_d[k] = sign_q[k];
            tag_d[k]  = tag_q[k];
            if (ld[k]) begin
                vld_d[k]  = vin;
                data_d[k] = cur;
                amt_d[k]  = amt;
                op_d[k]   = op;
                sign_d[k] = sgn;
                tag_d[k]  = tg;
`ifdef SHIFTER_FLAGS_EN
                carry_d[k] = cry;
                if (k == PIPE_REGS - 1) begin
                    zero_d = (cur == '0);
                end
`endif
            end
        end
    end

    // Stage registers: only the valid bits and the visible output fields are reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PIPE_REGS; k++) begin
            data_q[k] <= data_d[k];
            amt_q[k]  <= amt_d[k];
            op_q[k]   <= op_d[k];
            tag_q[k]  <= tag_d[k];
        end
        sign_q <= sign_d;
`ifdef SHIFTER_FLAGS_EN
        carry_q <= carry_d;
        zero_q  <= zero_d;
`endif
        if (rst) begin
            vld_q                <= '0;
            data_q[PIPE_REGS-1]  <= '0;
            tag_q[PIPE_REGS-1]   <= '0;
`ifdef SHIFTER_FLAGS_EN
            carry_q[PIPE_REGS-1] <= 1'b0;
            zero_q               <= 1'b1;
`endif
        end else begin
            vld_q <= vld_d;
        end
    end

    assign bus.in_ready  = stage0_ld;
    assign bus.out_valid = vld_q[PIPE_REGS-1];
    assign bus.out_data  = data_q[PIPE_REGS-1];
    assign bus.out_tag   = tag_q[PIPE_REGS-1];
`ifdef SHIFTER_FLAGS_EN
    assign bus.out_carry = carry_q[PIPE_REGS-1];
    assign bus.out_zero  = zero_q;
`endif
endmodule
